cpu_control: RTL

Multi-cycle sequencer for the RV32I datapath driven by `test_cpu`. The block latches the fetched instruction and walks each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK. It waits on ready handshakes from instruction and data memory and emits the per-cycle datapath enables: PC write, IR write, register-file write, ALU operand selects, writeback mux and memory requests. It also counts retired instructions.

---
 rtl/cpu_pkg.sv | 54 +++++
 rtl/cpu_control_decode.sv | 145 ++++++++++++++
 rtl/cpu_control.sv | 109 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings for the cpu_control sequencer
// Contents: state encodings, RV32I opcode constants, pc_src / wb_sel encodings,
//           the per-cycle control bundle and a legal-opcode helper.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } state_e;

    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;

    localparam logic [1:0] PC_SRC_PC4 = 2'd0;
    localparam logic [1:0] PC_SRC_IMM = 2'd1;
    localparam logic [1:0] PC_SRC_ALU = 2'd2;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

    typedef struct packed {
        logic       imem_req;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic       alu_src_b;
        logic       dmem_req;
        logic       dmem_we;
        logic       reg_write;
        logic [1:0] wb_sel;
    } ctrl_t;

    function automatic logic is_legal_opcode(input logic [6:0] opc);
        case (opc)
            OPC_OP_IMM, OPC_OP, OPC_LOAD, OPC_STORE, OPC_BRANCH,
            OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: is_legal_opcode = 1'b1;
            default:                               is_legal_opcode = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_control_decode.sv
// rtl/cpu_control_decode.sv - combinational next-state and enable map for cpu_control
// Optional feature macro: CPU_CONTROL_TRAP_EN (illegal opcode parks in TRAP).
// Ports:
//   state        in   current sequencer state
//   opcode       in   ir[6:0] from the registered IR
//   branch_taken in   ALU branch compare, used in EXECUTE of a branch
//   imem_ready   in   fetch handshake, used only in FETCH
//   dmem_ready   in   data handshake, used only in MEM
//   ctrl         out  datapath enable bundle for this cycle
//   next_state   out  state to load on the next edge
//   retire       out  this cycle completes an instruction
//   trap         out  (CPU_CONTROL_TRAP_EN only) sequencer is in TRAP
module cpu_control_decode
    import cpu_pkg::*;
(
    input  state_e     state,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output ctrl_t      ctrl,
    output state_e     next_state,
    output logic       retire
`ifdef CPU_CONTROL_TRAP_EN
    ,
    output logic       trap
`endif
);

    always_comb begin
        ctrl       = '0;
        next_state = state;
`ifdef CPU_CONTROL_TRAP_EN
        trap       = 1'b0;
`endif
        case (state)
            ST_FETCH: begin
                ctrl.imem_req = 1'b1;
                if (imem_ready) begin
                    ctrl.ir_write = 1'b1;
                    next_state    = ST_DECODE;
                end
            end

            ST_DECODE: begin
                if (is_legal_opcode(opcode)) begin
                    next_state = ST_EXECUTE;
                end else begin
`ifdef CPU_CONTROL_TRAP_EN
                    next_state = ST_TRAP;
`else
                    // Illegal opcode is skipped: advance PC and retire as a NOP.
                    ctrl.pc_write = 1'b1;
                    ctrl.pc_src   = PC_SRC_PC4;
                    next_state    = ST_FETCH;
`endif
                end
            end

            ST_EXECUTE: begin
                case (opcode)
                    OPC_OP_IMM, OPC_LUI: begin
                        ctrl.alu_src_b = 1'b1;
                        next_state     = ST_WRITEBACK;
                    end
                    OPC_OP: begin
                        next_state = ST_WRITEBACK;
                    end
                    OPC_AUIPC: begin
                        ctrl.alu_src_a = 1'b1;
                        ctrl.alu_src_b = 1'b1;
                        next_state     = ST_WRITEBACK;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        ctrl.alu_src_b = 1'b1;
                        next_state     = ST_MEM;
                    end
                    OPC_BRANCH: begin
                        ctrl.pc_write = 1'b1;
                        ctrl.pc_src   = branch_taken ? PC_SRC_IMM : PC_SRC_PC4;
                        next_state    = ST_FETCH;
                    end
                    OPC_JAL: begin
                        ctrl.pc_write = 1'b1;
                        ctrl.pc_src   = PC_SRC_IMM;
                        next_state    = ST_WRITEBACK;
                    end
                    OPC_JALR: begin
                        ctrl.pc_write = 1'b1;
                        ctrl.pc_src   = PC_SRC_ALU;
                        next_state    = ST_WRITEBACK;
                    end
                    // Only legal opcodes reach EXECUTE; recover to FETCH if not.
                    default: next_state = ST_FETCH;
                endcase
            end

            ST_MEM: begin
                ctrl.dmem_req = 1'b1;
                ctrl.dmem_we  = (opcode == OPC_STORE);
                if (dmem_ready) begin
                    if (opcode == OPC_STORE) begin
                        ctrl.pc_write = 1'b1;
                        ctrl.pc_src   = PC_SRC_PC4;
                        next_state    = ST_FETCH;
                    end else begin
                        next_state = ST_WRITEBACK;
                    end
                end
            end

            ST_WRITEBACK: begin
                ctrl.reg_write = 1'b1;
                next_state     = ST_FETCH;
                if (opcode == OPC_LOAD) begin
                    ctrl.wb_sel = WB_SEL_MEM;
                end else if (opcode == OPC_JAL || opcode == OPC_JALR) begin
                    ctrl.wb_sel = WB_SEL_PC4;
                end else begin
                    ctrl.wb_sel = WB_SEL_ALU;
                end
                // Jumps already loaded their target PC in EXECUTE.
                if (opcode != OPC_JAL && opcode != OPC_JALR) begin
                    ctrl.pc_write = 1'b1;
                    ctrl.pc_src   = PC_SRC_PC4;
                end
            end

`ifdef CPU_CONTROL_TRAP_EN
            ST_TRAP: begin
                trap       = 1'b1;
                next_state = ST_TRAP;
            end
`endif

            default: next_state = ST_FETCH;
        endcase
    end

    // Every path back to FETCH from a post-fetch state completes an instruction.
    assign retire = (next_state == ST_FETCH) &&
                    (state == ST_DECODE || state == ST_EXECUTE ||
                     state == ST_MEM || state == ST_WRITEBACK);

endmodule

// File: rtl/cpu_control.sv
// rtl/cpu_control.sv - multi-cycle RV32I control sequencer with retire counter
// Optional feature macro: CPU_CONTROL_TRAP_EN (adds trap port and sticky TRAP state).
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   instruction, imem_ready fetched word and its valid strobe
//   dmem_ready              data access completes this cycle
//   branch_taken            branch compare result, used in EXECUTE
//   imem_req, ir_write      fetch request and IR load
//   pc_write, pc_src        PC update and source select
//   alu_src_a, alu_src_b    ALU operand selects
//   dmem_req, dmem_we       data request and write qualifier
//   reg_write, wb_sel       register write and writeback mux select
//   state                   current state encoding (debug)
//   retired                 completed-instruction count
//   trap                    (CPU_CONTROL_TRAP_EN only) illegal opcode seen
module cpu_control
    import cpu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [XLEN-1:0]  instruction,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             branch_taken,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic             alu_src_b,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
`ifdef CPU_CONTROL_TRAP_EN
    ,
    output logic             trap
`endif
);

    state_e            state_q, state_d;
    logic [XLEN-1:0]   ir_q, ir_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    ctrl_t             ctrl;
    ctrl_t             ctrl_o;
    state_e            next_state;
    logic              retire;
`ifdef CPU_CONTROL_TRAP_EN
    logic              trap_raw;
`endif

    cpu_control_decode u_decode (
        .state        (state_q),
        .opcode       (ir_q[6:0]),
        .branch_taken (branch_taken),
        .imem_ready   (imem_ready),
        .dmem_ready   (dmem_ready),
        .ctrl         (ctrl),
        .next_state   (next_state),
        .retire       (retire)
`ifdef CPU_CONTROL_TRAP_EN
        ,
        .trap         (trap_raw)
`endif
    );

    always_comb begin
        state_d   = next_state;
        ir_d      = ctrl.ir_write ? instruction : ir_q;
        retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
        // Reset wins over any in-flight instruction: no retire, no IR load.
        if (reset) begin
            state_d   = ST_FETCH;
            ir_d      = '0;
            retired_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        state_q   <= state_d;
        ir_q      <= ir_d;
        retired_q <= retired_d;
    end

    // All outputs are held at zero while reset is asserted.
    assign ctrl_o    = reset ? '0 : ctrl;
    assign imem_req  = ctrl_o.imem_req;
    assign ir_write  = ctrl_o.ir_write;
    assign pc_write  = ctrl_o.pc_write;
    assign pc_src    = ctrl_o.pc_src;
    assign alu_src_a = ctrl_o.alu_src_a;
    assign alu_src_b = ctrl_o.alu_src_b;
    assign dmem_req  = ctrl_o.dmem_req;
    assign dmem_we   = ctrl_o.dmem_we;
    assign reg_write = ctrl_o.reg_write;
    assign wb_sel    = ctrl_o.wb_sel;
    assign state     = reset ? 3'd0 : state_q;
    assign retired   = reset ? '0 : retired_q;
`ifdef CPU_CONTROL_TRAP_EN
    assign trap      = ~reset & trap_raw;
`endif

endmodule
